// File: rtl/regfile_write_queue_pkg.sv
// Shared widths and the queue entry layout for the register-file write queue.
// Pure declarations: no latency, no flow control.
package regfile_write_queue_pkg;

  localparam int RF_WORD_SIZE = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int WQ_DEPTH     = 4;

  typedef struct packed {
    logic                    live;
    logic [REG_ADDR_W-1:0]   addr;
    logic [RF_WORD_SIZE-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/wq_bypass_lookup.sv
// Youngest-match search of the queue for one read address; purely combinational.
// No backpressure: result is valid in the same cycle as the lookup address.
module wq_bypass_lookup #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 4,
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                 live,
  input  logic [DEPTH-1:0][ADDR_W-1:0]     addr,
  input  logic [DEPTH-1:0][WORD_SIZE-1:0]  data,
  input  logic [PW-1:0]                    tail,
  input  logic [ADDR_W-1:0]                q_addr,
  output logic                             hit,
  output logic [WORD_SIZE-1:0]             byp
);

  logic [PW-1:0] idx;

  // Walk oldest (tail-DEPTH) to youngest (tail-1); later matches overwrite earlier ones.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (live[idx] && (addr[idx] == q_addr) && (q_addr != '0)) begin
        hit = 1'b1;
        byp = data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Buffers multi-cycle write-backs and drains them into the register file port when the pipeline is idle.
// Latency: earliest drain one cycle after accept; in_ready drops only when all DEPTH slots are occupied.
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter int WORD_SIZE = RF_WORD_SIZE,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DEPTH     = WQ_DEPTH,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 wb_we,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic [ADDR_W-1:0]    A3,
  output logic [WORD_SIZE-1:0] WD3,
  output logic                 WE3,
  input  logic [ADDR_W-1:0]    q_A1,
  input  logic [ADDR_W-1:0]    q_A2,
  output logic                 hit1,
  output logic                 hit2,
  output logic [WORD_SIZE-1:0] byp1,
  output logic [WORD_SIZE-1:0] byp2,
  output logic [CW-1:0]        count
);

  logic [DEPTH-1:0]                live_q;
  logic [DEPTH-1:0][ADDR_W-1:0]    addr_q;
  logic [DEPTH-1:0][WORD_SIZE-1:0] data_q;
  logic [PW-1:0]                   head;
  logic [PW-1:0]                   tail;

  logic push;
  logic pop;
  logic kill;

  assign in_ready = (count != CW'(DEPTH));
  assign pop      = !wb_we && (count != '0);
  assign push     = in_valid && in_ready && (in_addr != '0);
  // A pipeline write is younger than anything queued, so it supersedes same-address entries.
  assign kill     = wb_we && (wb_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      live_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && (addr_q[i] == wb_addr)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        live_q[tail] <= !(kill && (in_addr == wb_addr));
        addr_q[tail] <= in_addr;
        data_q[tail] <= in_data;
        tail         <= tail + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_comb begin
    A3  = '0;
    WD3 = '0;
    WE3 = 1'b0;
    if (!rst) begin
      A3  = '0;
      WD3 = '0;
      WE3 = 1'b0;
    end else if (wb_we) begin
      A3  = wb_addr;
      WD3 = wb_data;
      WE3 = 1'b1;
    end else if (count != '0) begin
      A3  = addr_q[head];
      WD3 = data_q[head];
      WE3 = live_q[head] && (addr_q[head] != '0);
    end
  end

  wq_bypass_lookup #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_byp1 (
    .live(live_q), .addr(addr_q), .data(data_q), .tail(tail),
    .q_addr(q_A1), .hit(hit1), .byp(byp1)
  );

  wq_bypass_lookup #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_byp2 (
    .live(live_q), .addr(addr_q), .data(data_q), .tail(tail),
    .q_addr(q_A2), .hit(hit2), .byp(byp2)
  );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with a queue-based reference model checked every cycle.
// Literal expectations at key points pin the reference model itself.
module tb_regfile_write_queue;
  import regfile_write_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [4:0]  q_A1;
  logic [4:0]  q_A2;
  logic        hit1;
  logic        hit2;
  logic [31:0] byp1;
  logic [31:0] byp2;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  regfile_write_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .A3(A3), .WD3(WD3), .WE3(WE3),
    .q_A1(q_A1), .q_A2(q_A2), .hit1(hit1), .hit2(hit2),
    .byp1(byp1), .byp2(byp2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending writes, oldest first.
  wq_entry_t mq[$];
  wq_entry_t ne;
  bit        m_acc;
  bit        m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      m_acc = in_valid && (mq.size() != DEPTH);
      m_pop = !wb_we && (mq.size() > 0);
      if (wb_we && wb_addr != 0)
        foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].live = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (m_acc && in_addr != 0) begin
        ne.live = !(wb_we && wb_addr != 0 && wb_addr == in_addr);
        ne.addr = in_addr;
        ne.data = in_data;
        mq.push_back(ne);
      end
    end
  end

  logic [4:0]  e_a3;
  logic [31:0] e_wd3;
  logic        e_we3;
  logic        e_h1, e_h2;
  logic [31:0] e_b1, e_b2;

  always @(negedge clk) begin
    if (rst && chk_en) begin
      e_a3 = 0; e_wd3 = 0; e_we3 = 0;
      if (wb_we) begin
        e_a3 = wb_addr; e_wd3 = wb_data; e_we3 = 1'b1;
      end else if (mq.size() > 0) begin
        e_a3 = mq[0].addr; e_wd3 = mq[0].data; e_we3 = mq[0].live && mq[0].addr != 0;
      end
      e_h1 = 0; e_b1 = 0; e_h2 = 0; e_b2 = 0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!e_h1 && mq[i].live && q_A1 != 0 && mq[i].addr == q_A1) begin e_h1 = 1; e_b1 = mq[i].data; end
        if (!e_h2 && mq[i].live && q_A2 != 0 && mq[i].addr == q_A2) begin e_h2 = 1; e_b2 = mq[i].data; end
      end
      chk("m_in_ready", in_ready, mq.size() != DEPTH);
      chk("m_count", count, mq.size());
      chk("m_we3", WE3, e_we3);
      chk("m_a3", A3, e_a3);
      chk("m_wd3", WD3, e_wd3);
      chk("m_hit1", hit1, e_h1);
      chk("m_byp1", byp1, e_b1);
      chk("m_hit2", hit2, e_h2);
      chk("m_byp2", byp2, e_b2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] a, input logic [31:0] d);
    in_valid = v; in_addr = a; in_data = d;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0);
    set_wb(0, 0, 0);
    q_A1 = 0; q_A2 = 0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_we3", WE3, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_hit1", hit1, 0);
    chk("rst_byp2", byp2, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;

    // Basic drain
    set_in(1, 10, 32'hFFFF_FFFF);
    #1 chk("basic_pre_count", count, 0);
    tick();
    set_in(0, 0, 0);
    #1;
    chk("basic_a3", A3, 10);
    chk("basic_wd3", WD3, 32'hFFFF_FFFF);
    chk("basic_we3", WE3, 1);
    tick();
    #1;
    chk("basic_post_count", count, 0);
    chk("basic_post_we3", WE3, 0);

    // Pipeline priority
    set_in(1, 5, 32'h1);
    tick();
    set_in(0, 0, 0);
    set_wb(1, 7, 32'h2);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("prio_a3", A3, 7);
      chk("prio_wd3", WD3, 32'h2);
      chk("prio_count", count, 1);
      tick();
    end
    set_wb(0, 0, 0);
    #1;
    chk("prio_drain_a3", A3, 5);
    chk("prio_drain_wd3", WD3, 32'h1);
    chk("prio_drain_we3", WE3, 1);
    tick();
    #1 chk("prio_empty", count, 0);

    // Kill by younger pipeline write
    set_in(1, 9, 32'hA);
    set_wb(1, 7, 32'h2);
    tick();
    set_in(0, 0, 0);
    set_wb(1, 9, 32'hB);
    q_A1 = 9;
    #1;
    chk("kill_pre_hit1", hit1, 1);
    chk("kill_pre_byp1", byp1, 32'hA);
    tick();
    set_wb(0, 0, 0);
    #1;
    chk("kill_hit1", hit1, 0);
    chk("kill_count", count, 1);
    chk("kill_a3", A3, 9);
    chk("kill_we3", WE3, 0);
    tick();
    #1 chk("kill_empty", count, 0);
    q_A1 = 0;

    // Full, then drain, then refill across the pointer wrap
    for (int r = 0; r < 2; r++) begin
      set_wb(1, 20, 32'h99);
      for (int i = 0; i < 4; i++) begin
        set_in(1, 5'(1 + 10 * r + i), 32'h10 + 32'(16 * r + i));
        tick();
      end
      set_in(0, 0, 0);
      q_A1 = 5'(2 + 10 * r);
      #1;
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      chk("full_hit1", hit1, 1);
      chk("full_byp1", byp1, 32'h11 + 32'(16 * r));
      set_in(1, 5, 32'h14);
      tick();
      set_in(0, 0, 0);
      set_wb(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        #1;
        chk("drain_a3", A3, 1 + 10 * r + i);
        chk("drain_wd3", WD3, 32'h10 + 32'(16 * r + i));
        chk("drain_we3", WE3, 1);
        tick();
      end
      #1 chk("drain_empty", count, 0);
      q_A1 = 0;
    end

    // Register 0 discard, youngest-wins bypass, same-cycle kill
    set_wb(1, 20, 32'h99);
    set_in(1, 0, 32'hDEAD);
    tick();
    #1 chk("r0_count", count, 0);
    set_in(1, 3, 32'h5);
    tick();
    set_in(1, 3, 32'h6);
    tick();
    set_in(1, 4, 32'h7);
    set_wb(1, 4, 32'h8);
    tick();
    set_in(0, 0, 0);
    set_wb(1, 20, 32'h99);
    q_A2 = 3;
    q_A1 = 4;
    #1;
    chk("byp_hit2", hit2, 1);
    chk("byp_byp2", byp2, 32'h6);
    chk("byp_count", count, 3);
    chk("samekill_hit1", hit1, 0);
    tick();
    set_wb(0, 0, 0);
    #1 chk("r0_first_a3", A3, 3);
    repeat (3) tick();
    #1 chk("r0_empty", count, 0);
    q_A1 = 0; q_A2 = 0;

    // Asynchronous reset in the middle of a cycle
    set_wb(1, 20, 32'h99);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'(21 + i), 32'h30 + 32'(i));
      tick();
    end
    set_in(0, 0, 0);
    set_wb(0, 0, 0);
    q_A1 = 22;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_we3", WE3, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_hit1", hit1, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) tick();
    #1 chk("post_rst_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side companion to `registerFile`. It buffers register write-back requests from multi-cycle units (loads, multiply) and drains them into the register file write port (A3/WD3/WE3).
- The main pipeline write-back has priority on that port. The queue drains only on cycles when the pipeline is not writing.
- Provides a bypass lookup so readers see queued but not yet committed values.

Parameters:
- WORD_SIZE, 32, data width; matches the `WORD_SIZE` used by registerFile.
- ADDR_W, 5, register address width (32 registers).
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- in_valid  in  1  multi-cycle unit presents a write request.
- in_ready  out  1  queue can accept; transfer occurs when in_valid && in_ready at posedge.
- in_addr  in  ADDR_W  destination register of the request.
- in_data  in  WORD_SIZE  write data of the request.
- wb_we  in  1  pipeline write-back enable (priority source).
- wb_addr  in  ADDR_W  pipeline write-back register.
- wb_data  in  WORD_SIZE  pipeline write-back data.
- A3  out  ADDR_W  register file write address.
- WD3  out  WORD_SIZE  register file write data.
- WE3  out  1  register file write enable.
- q_A1, q_A2  in  ADDR_W  bypass lookup addresses (the decode-stage A1/A2).
- hit1, hit2  out  1  a live queued entry matches q_A1 / q_A2.
- byp1, byp2  out  WORD_SIZE  data of the youngest matching live entry; 0 when no hit.
- count  out  $clog2(DEPTH)+1  number of occupied entries, including killed entries.

Behaviour:
- Storage: circular buffer of DEPTH entries {live, addr, data}, plus head/tail pointers and count. Pointers wrap modulo DEPTH.
- Reset (rst=0, asynchronous):
  - head = tail = count = 0; all live bits cleared.
  - Outputs: in_ready=1, WE3=0, A3=0, WD3=0, hit1=hit2=0, byp1=byp2=0.
  - Any in-flight request is dropped.
- in_ready = (count != DEPTH). It is registered-state derived; no same-cycle pop-to-push pass-through when full.
- Accept rule (in_valid && in_ready at posedge):
  - in_addr == 0: request is consumed and discarded (register 0 is hard-wired). No enqueue, count unchanged.
  - Otherwise: enqueue at tail with live=1, tail++, count++.
- Write port mux (combinational from current state and wb_*):
  - wb_we=1: A3=wb_addr, WD3=wb_data, WE3=1; no pop.
  - Else if count>0: pop head at posedge. A3/WD3 = head entry; WE3 = head.live && head.addr != 0. Killed entries pop silently with WE3=0.
  - Else: WE3=0, A3=0, WD3=0.
- Latency: a request accepted at posedge N can appear on the port at earliest cycle N+1 (empty queue, wb_we=0).
- Ordering / kill rule: a pipeline write is always younger than every queued entry.
  - wb_we=1 with wb_addr != 0: at that posedge, clear live on every entry with addr == wb_addr.
  - The same applies to a request enqueued in the same cycle with the same address. It is enqueued with live=0.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Bypass (combinational): hitN = some live entry has addr == q_AN and q_AN != 0. bypN = data of the youngest such entry, searched from tail-1 backward.
- Throughput: one drain per cycle when wb_we=0. A continuous wb_we stream starves the queue by design; the upstream unit stalls on in_ready=0.

Decomposition:
- Shared package/header: `WORD_SIZE` (existing define), REG_ADDR_W=5, the entry struct/typedef {live, addr, data}.
- One natural sub-module, `wq_bypass_lookup`: youngest-match priority search over DEPTH entries relative to tail. It is instantiated twice, once per read port.
- Queue control and the write mux stay in the top module.

Test Plan:
- Reset mid-operation: enqueue 3 entries, pull rst=0 between clock edges. Required: count=0, WE3=0, in_ready=1 immediately, with no posedge needed.
- Basic drain: push {addr=10, data=32'hFFFF_FFFF} with wb_we=0. Required: next cycle A3=10, WD3=32'hFFFF_FFFF, WE3=1; then count=0 and WE3=0.
- Priority: queue holds {5, 32'h1}, wb_we=1 {7, 32'h2} for 2 cycles. Required: A3=7 both cycles, count stays 1; {5, 32'h1} drains on the third cycle.
- Kill: queue holds {9, 32'hA}, then wb_we=1 {9, 32'hB}. Required: after the wb cycle, hit for q_A1=9 is 0; the queued entry later pops with WE3=0.
- Full/wrap: with wb_we=1 held, push 4 entries {1..4, 32'h10..32'h13}. Required: in_ready=0 and count=4; a fifth push is not accepted. Drop wb_we: drains in order 1,2,3,4; refill 4 more to exercise pointer wrap.
- Register 0 and bypass: push {0, 32'hDEAD}. Required: count unchanged, never written. Push {3, 32'h5} then {3, 32'h6}. Required: q_A2=3 gives hit2=1, byp2=32'h6.
